smul_seq: RTL

- Sequential signed shift-add multiplier; the inverse arithmetic companion to the team's repeated-subtraction signed divider.
- Same go/rdy handshake style: a start pulse loads the operands, the block iterates over the multiplier bits, then flags completion.
- Provides a full-width signed product plus a saturated WIDTH-bit product with overflow flag, for datapaths that need a same-width result.

---
 rtl/smul_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/smul_seq.sv
// Sequential signed shift-add multiplier with go/rdy handshake.
// Produces the full 2*WIDTH-bit signed product plus a saturated WIDTH-bit copy with an overflow flag.
module smul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     product_sat,
  output logic                 ovf,
  output logic                 rdy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_NEG,
    S_END
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   product_q, product_d;
  logic [WIDTH-1:0] product_sat_q, product_sat_d;
  logic            ovf_q, ovf_d;
  logic            rdy_q, rdy_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [PW-1:0]    signed_res;
  logic [WIDTH:0]   res_top;
  logic             res_fits;
  logic [WIDTH-1:0] res_sat;

  // -2^(WIDTH-1) maps onto itself, which is exactly its unsigned magnitude.
  assign abs_a = multiplicand[WIDTH-1] ? (~multiplicand + WIDTH'(1)) : multiplicand;
  assign abs_b = multiplier[WIDTH-1]   ? (~multiplier + WIDTH'(1))   : multiplier;

  assign signed_res = neg_q ? (~acc_q + PW'(1)) : acc_q;
  // The value fits in WIDTH signed bits only when the top WIDTH+1 bits are all sign copies.
  assign res_top  = signed_res[PW-1:WIDTH-1];
  assign res_fits = (&res_top) | ~(|res_top);
  assign res_sat  = res_fits ? signed_res[WIDTH-1:0]
                  : (signed_res[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}});

  // NOTE: every _d starts as its _q, so no path through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    neg_d         = neg_q;
    product_d     = product_q;
    product_sat_d = product_sat_q;
    ovf_d         = ovf_q;
    rdy_d         = rdy_q;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          neg_d    = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          rdy_d    = 1'b0;
          state_d  = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_NEG;
      end
      S_NEG: begin
        product_d     = signed_res;
        product_sat_d = res_sat;
        ovf_d         = ~res_fits;
        state_d       = S_END;
      end
      S_END: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      neg_q         <= 1'b0;
      product_q     <= '0;
      product_sat_q <= '0;
      ovf_q         <= 1'b0;
      rdy_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      neg_q         <= neg_d;
      product_q     <= product_d;
      product_sat_q <= product_sat_d;
      ovf_q         <= ovf_d;
      rdy_q         <= rdy_d;
    end
  end

  assign product     = product_q;
  assign product_sat = product_sat_q;
  assign ovf         = ovf_q;
  assign rdy         = rdy_q;

endmodule
